// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: latches the winning op,
// holds it on the ALU through an issue cycle and a result cycle, then pulses the response.
//
// state | meaning
// IDLE  | no op in flight; accept allowed
// EXEC  | ALU captures op_a/op_b at the end of this cycle; no accept
// DONE  | ALU result/flags valid for op_ctrl; register response; accept allowed
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_ctrl0,
  input  logic [3:0]  req_ctrl1,
  input  logic [15:0] req_a0,
  input  logic [15:0] req_b0,
  input  logic [15:0] req_a1,
  input  logic [15:0] req_b1,
  output logic        alu_resetn,
  output logic [3:0]  alu_ctrl,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_y,
  input  logic        alu_c,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
  input  logic        alu_s,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_y,
  output logic [4:0]  rsp_flags,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic        grant;
  logic        window;
  logic        accept;
  logic [3:0]  op_ctrl;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_id;

  assign alu_resetn = ~reset;
  assign alu_ctrl   = op_ctrl;
  assign alu_a      = op_a;
  assign alu_b      = op_b;
  assign busy       = (state != IDLE);

  // on a tie the requester that did not win last time goes next
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    window    = ((state == IDLE) || (state == DONE)) && !reset;
    if (window && req_valid[grant]) req_ready[grant] = 1'b1;
    accept = |req_ready;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      op_ctrl   <= 4'd0;
      op_a      <= 16'd0;
      op_b      <= 16'd0;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= 16'd0;
      rsp_flags <= 5'd0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= (state == DONE);
      // op registers still hold the finishing op here, so alu_ctrl matches the flags
      if (state == DONE) begin
        rsp_id    <= op_id;
        rsp_y     <= alu_y;
        rsp_flags <= {alu_c, alu_z, alu_n, alu_v, alu_s};
      end
      if (accept) begin
        last    <= grant;
        op_id   <= grant;
        op_ctrl <= grant ? req_ctrl1 : req_ctrl0;
        op_a    <= grant ? req_a1 : req_a0;
        op_b    <= grant ? req_b1 : req_b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stand-in, accept/response scoreboard,
// directed vector table, contention/flag-hold/reset sequences and random traffic.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_ctrl0, req_ctrl1;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic        alu_resetn;
  logic [3:0]  alu_ctrl;
  logic [15:0] alu_a, alu_b, alu_y;
  logic        alu_c, alu_z, alu_n, alu_v, alu_s;
  logic        rsp_valid, rsp_id;
  logic [15:0] rsp_y;
  logic [4:0]  rsp_flags;
  logic        busy;

  alu_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .alu_resetn(alu_resetn), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_s(alu_s),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // returns {y[15:0], c, z, n, v, s}
  function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] y;
    logic c, v, n;
    w = 17'd0; y = 16'd0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        y = w[15:0];
        c = w[16];
        v = (a[15] == b[15]) && (y[15] != a[15]);
      end
      OP_SUB: begin
        y = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (y[15] != a[15]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: y = 16'd0;
    endcase
    n = y[15];
    return {y, c, (y == 16'd0), n, v, n ^ v};
  endfunction

  // ALU stand-in: operands registered, result and flags combinational on ctrl
  logic [15:0] ra, rb;
  logic [20:0] alu_out;
  always @(posedge clk) begin
    if (!alu_resetn) begin
      ra <= 16'd0;
      rb <= 16'd0;
    end else begin
      ra <= alu_a;
      rb <= alu_b;
    end
  end
  assign alu_out = alu_fn(alu_ctrl, ra, rb);
  assign alu_y = alu_out[20:5];
  assign {alu_c, alu_z, alu_n, alu_v, alu_s} = alu_out[4:0];

  // Reference model: an accept blocks the following cycle; its response is due 3 cycles later.
  typedef struct { int due; bit id; logic [15:0] y; logic [4:0] f; } exp_t;
  exp_t        exp_q[$];
  bit          m_last = 1'b1;
  bit          prev_acc = 1'b0, prev2_acc = 1'b0, rst_prev = 1'b0;
  logic [35:0] cur_op = '0;
  logic [21:0] rsp_log[$];
  bit          acc_log[$];
  int          acc_cyc[$];

  always @(negedge clk) begin
    bit win, g;
    logic [1:0] exp_rdy;
    logic [3:0] gc;
    logic [15:0] ga, gb;
    logic [20:0] r;
    bit exp_rv;
    if (reset) begin
      chk("ready_in_reset", 64'(req_ready), 64'd0);
      chk("alu_resetn_in_reset", 64'(alu_resetn), 64'd0);
      if (rst_prev) begin
        chk("rsp_valid_reset", 64'(rsp_valid), 64'd0);
        chk("busy_reset", 64'(busy), 64'd0);
        chk("rsp_regs_reset", 64'({rsp_id, rsp_y, rsp_flags}), 64'd0);
        chk("alu_op_reset", 64'({alu_ctrl, alu_a, alu_b}), 64'd0);
      end
      exp_q.delete();
      m_last = 1'b1; prev_acc = 1'b0; prev2_acc = 1'b0; rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      win = !prev_acc;
      g = (req_valid == 2'b10) ? 1'b1 : (req_valid == 2'b11) ? ~m_last : 1'b0;
      exp_rdy = (win && (req_valid != 2'b00)) ? (g ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("alu_resetn", 64'(alu_resetn), 64'd1);
      chk("busy", 64'(busy), 64'(prev_acc || prev2_acc));
      if (prev_acc || prev2_acc) chk("alu_op_hold", 64'({alu_ctrl, alu_a, alu_b}), 64'(cur_op));
      exp_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
        chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
        chk("rsp_y", 64'(rsp_y), 64'(exp_q[0].y));
        chk("rsp_flags", 64'(rsp_flags), 64'(exp_q[0].f));
        void'(exp_q.pop_front());
      end
      if (rsp_valid) rsp_log.push_back({rsp_id, rsp_y, rsp_flags});
      if ((req_valid & req_ready) != 2'b00) begin
        acc_log.push_back(req_ready[1]);
        acc_cyc.push_back(cyc);
      end
      if (exp_rdy != 2'b00) begin
        gc = g ? req_ctrl1 : req_ctrl0;
        ga = g ? req_a1 : req_a0;
        gb = g ? req_b1 : req_b0;
        r = alu_fn(gc, ga, gb);
        exp_q.push_back('{cyc + 3, g, r[20:5], r[4:0]});
        m_last = g;
        cur_op = {gc, ga, gb};
      end
      prev2_acc = prev_acc;
      prev_acc = (exp_rdy != 2'b00);
    end
  end

  int t_issue;

  task automatic issue(input bit id, input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    if (id) begin req_ctrl1 = c; req_a1 = a; req_b1 = b; req_valid = 2'b10; end
    else    begin req_ctrl0 = c; req_a0 = a; req_b0 = b; req_valid = 2'b01; end
    t_issue = cyc;
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic wait_rsp(input string nm, output logic [21:0] r, output int lat);
    bit got = 1'b0;
    r = '0;
    lat = -1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        r = {rsp_id, rsp_y, rsp_flags};
        lat = cyc - t_issue;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s: no rsp_valid within 8 cycles", nm);
    end
  endtask

  typedef struct { bit id; logic [3:0] ctrl; logic [15:0] a; logic [15:0] b; logic [15:0] y; logic [4:0] f; } vec_t;
  vec_t vecs[8];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [21:0] r;
    int lat;
    // flags column is {c,z,n,v,s}
    vecs[0] = '{1'b0, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b00110};
    vecs[1] = '{1'b1, OP_SUB, 16'h0005, 16'h0005, 16'h0000, 5'b01000};
    vecs[2] = '{1'b0, OP_ADD, 16'h8000, 16'h8000, 16'h0000, 5'b11011};
    vecs[3] = '{1'b1, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 5'b10101};
    vecs[4] = '{1'b0, OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000};
    vecs[5] = '{1'b1, 4'hF,   16'h1234, 16'h5678, 16'h0000, 5'b01000};
    vecs[6] = '{1'b0, OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b00011};
    vecs[7] = '{1'b1, OP_XOR, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b01000};

    // reset with both requesters valid, then contention straight out of reset
    reset = 1'b1;
    req_valid = 2'b11;
    req_ctrl0 = OP_ADD; req_a0 = 16'h0010; req_b0 = 16'h0001;
    req_ctrl1 = OP_ADD; req_a1 = 16'h0200; req_b1 = 16'h0020;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (5) @(posedge clk);
    chk("contention_n_acc", 64'(acc_log.size() >= 4), 64'd1);
    chk("contention_n_rsp", 64'(rsp_log.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contention_grant%0d", i), 64'(acc_log[i]), 64'(i % 2));
      chk($sformatf("contention_rsp_id%0d", i), 64'(rsp_log[i][21]), 64'(i % 2));
      chk($sformatf("contention_rsp_y%0d", i), 64'(rsp_log[i][20:5]), (i % 2) ? 64'h0220 : 64'h0011);
    end
    for (int i = 1; i < 4; i++)
      chk($sformatf("contention_spacing%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd2);

    // directed vector table, one op at a time from IDLE
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].id, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      wait_rsp($sformatf("vec%0d", i), r, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("vec%0d_id", i), 64'(r[21]), 64'(vecs[i].id));
      chk($sformatf("vec%0d_y", i), 64'(r[20:5]), 64'(vecs[i].y));
      chk($sformatf("vec%0d_flags", i), 64'(r[4:0]), 64'(vecs[i].f));
    end

    // flag hold: req0 ADD accepted in DONE of a req1 AND
    repeat (2) @(posedge clk);
    rsp_log.delete(); acc_log.delete(); acc_cyc.delete();
    #1;
    req_ctrl1 = OP_AND; req_a1 = 16'hFFFF; req_b1 = 16'h00FF; req_valid = 2'b10;
    @(posedge clk); #1;
    req_ctrl0 = OP_ADD; req_a0 = 16'h8000; req_b0 = 16'h8000; req_valid = 2'b01;
    repeat (2) @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    chk("hold_n_acc", 64'(acc_log.size()), 64'd2);
    chk("hold_accept_in_done", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
    chk("hold_and_rsp", 64'(rsp_log[0]), 64'({1'b1, 16'h00FF, 5'b00000}));
    chk("hold_add_rsp", 64'(rsp_log[1]), 64'({1'b0, 16'h0000, 5'b11011}));

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom);
      req_ctrl0 = 4'($urandom_range(0, 7));
      req_ctrl1 = 4'($urandom_range(0, 7));
      req_a0 = 16'($urandom); req_b0 = 16'($urandom);
      req_a1 = 16'($urandom); req_b1 = 16'($urandom);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (6) @(posedge clk);

    // reset during EXEC drops the op; a fresh op then completes normally
    rsp_log.delete();
    issue(1'b0, OP_ADD, 16'h0001, 16'h0002);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    chk("reset_midop_no_rsp", 64'(rsp_log.size()), 64'd0);
    issue(1'b1, OP_SUB, 16'h000A, 16'h0003);
    wait_rsp("after_reset", r, lat);
    chk("after_reset_latency", 64'(lat), 64'd3);
    chk("after_reset_rsp", 64'(r), 64'({1'b1, 16'h0007, 5'b00000}));
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single QUAD.nibble ALU between two requesters, e.g. requester 0 = execute stage and requester 1 = address/branch-target unit. It arbitrates round-robin and latches the winning operation. It drives the ALU through one issue cycle and one result cycle, holding `ctrl` stable across both so the ALU's combinational C/V flags refer to the right opcode. It then returns the result and the five flags to the winner as a one-cycle response pulse.

## Interface
- Parameters: none. Two requesters and a 16-bit datapath are fixed by the ALU.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid[1:0]` in 2: requester i has an operation pending.
- `req_ready[1:0]` out 2: operation of requester i accepted this cycle; valid&&ready = transfer.
- `req_ctrl0`, `req_ctrl1` in 4 each: ALU opcode (`ALU_OP_*` constants).
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 16 each: signed operands.
- `alu_resetn` out 1: ALU reset, = ~reset (combinational).
- `alu_ctrl` out 4: to ALU `ctrl`.
- `alu_a`, `alu_b` out 16 each: to ALU `a`/`b`.
- `alu_y` in 16: from ALU `y`.
- `alu_c`, `alu_z`, `alu_n`, `alu_v`, `alu_s` in 1 each: from ALU flags.
- `rsp_valid` out 1: one-cycle result pulse; no backpressure, so the requester must take it.
- `rsp_id` out 1: requester the response belongs to.
- `rsp_y` out 16: result.
- `rsp_flags` out 5: {c,z,n,v,s}.
- `busy` out 1: state != IDLE.

## Operation
- Op registers `op_ctrl`, `op_a`, `op_b`, `op_id` drive `alu_ctrl`/`alu_a`/`alu_b` directly in every state.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: accept allowed. On accept, latch the op and go to EXEC; otherwise stay.
  - EXEC: the ALU captures `op_a`/`op_b` at the end of this cycle. Always go to DONE. No accept.
  - DONE: `alu_y` and flags are valid for the op and `alu_ctrl` still equals `op_ctrl`. Register `alu_y`, the flags and `op_id` into the rsp registers and set `rsp_valid` for the next cycle. Accept is allowed: on accept go to EXEC, else go to IDLE.
- Accept window: state is IDLE or DONE. `grant` is computed combinationally from `req_valid` and pointer `last`.
  - Only one requester valid: it wins.
  - Both valid: the requester != `last` wins.
  - `req_ready[grant]` = window && `req_valid[grant]`; the other ready bit is 0.
  - `last` <= grant on each accept.
- Opcode is not validated. Any 4-bit value is forwarded; undefined codes yield the ALU's default result (0).
- Reset, including mid-operation: state→IDLE, `last`→1 (requester 0 wins the first tie), op and rsp registers→0, `rsp_valid`→0. An in-flight op is dropped with no response. `alu_resetn` low for the duration.

## Timing
- Reset values: `req_ready`=0 while reset is high, `rsp_valid`=0, `rsp_id`=0, `rsp_y`=0, `rsp_flags`=0, `busy`=0, `alu_ctrl`/`alu_a`/`alu_b`=0.
- Latency: accept at cycle T (IDLE) → EXEC at T+1 → DONE at T+2 → `rsp_valid` high in T+3 only.
- Throughput: with continuous requests, one accept every 2 cycles (DONE→EXEC→DONE…); responses every 2 cycles.
- `req_ready` depends combinationally on `req_valid` and state; requesters must not make `req_valid` depend on `req_ready`.
- `rsp_*` hold their last value after the pulse; only the `rsp_valid` pulse marks a new result.
- Accept in DONE is legal: response for op k (cycle after DONE) coincides with EXEC of op k+1.

## Test plan
- Reset then idle: hold reset 3 cycles with valids high → `req_ready`=0, `rsp_valid`=0, `alu_resetn`=0, all outputs 0. Release → first grant to requester 0.
- Single ADD, req0: ctrl=`ALU_OP_ADD`, a=16'h7FFF, b=16'h0001 at T → `req_ready[0]`=1 at T. `rsp_valid`=1 at T+3 with id=0, y=16'h8000, flags c=0 z=0 n=1 v=1 s=0.
- SUB zero, req1: a=16'h0005, b=16'h0005 → y=0, z=1, n=0, c=0, v=0, s=0, id=1.
- Contention: both valid continuously with distinct ADDs → grants alternate 0,1,0,1. Accepts every 2 cycles (accept in DONE). Each response carries the correct id and y. The tie after reset goes to 0.
- Flag hold check: req0 ADD 16'h8000+16'h8000 accepted in DONE of a prior req1 AND → ADD response y=0, c=1, v=1, z=1, s=1. The AND response has c=v=0.
- Reset mid-op: assert reset in EXEC → no `rsp_valid` ever for that op. After release, a new op completes normally with 3-cycle latency.
